line_window_gen: RTL and testbench

Parametrised K×K sliding-window generator for the MobileNet dataflow path. It sits between the pixel streamer and the depthwise/pointwise convolution engines. It buffers K-1 image rows of CH-channel pixels in block RAM and emits full K×K×CH windows with runtime frame size, stride 1/2, and ready/valid backpressure on both sides. A frame is launched by a start pulse; windows are emitted only for fully populated (valid-convolution) positions.

---
 rtl/dataflow_pkg.sv | 16 +
 rtl/lb_row_ram.sv | 33 +++
 rtl/line_window_gen.sv | 248 ++++++++++++++++++++++++
 tb/tb_line_window_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared constants for the MobileNet dataflow path: stride encoding,
// legal window-size range and the line_window_gen control states.
package dataflow_pkg;

  localparam logic STRIDE_1 = 1'b0;
  localparam logic STRIDE_2 = 1'b1;

  localparam int K_MIN = 3;
  localparam int K_MAX = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lwg_state_t;

endpackage

// File: rtl/lb_row_ram.sv
// One line-buffer row: simple dual-port block RAM, one write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents. The read enable lets the caller freeze
// o_rd_data while the pipeline is stalled.
module lb_row_ram
  import dataflow_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; holds its output when not enabled
  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/line_window_gen.sv
// K x K sliding-window generator. K-1 row RAMs hold the previous rows; each
// accepted pixel reads its column from every RAM (stage 1), then the K-row
// column vector is shifted into the window register (stage 2). Windows are
// presented only at fully populated, stride-aligned positions.
module line_window_gen
  import dataflow_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CH             = 1,
  parameter int K              = 3,
  parameter int MAX_IMG_WIDTH  = 64,
  parameter int MAX_IMG_HEIGHT = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [$clog2(MAX_IMG_WIDTH+1)-1:0]    cfg_width,
  input  logic [$clog2(MAX_IMG_HEIGHT+1)-1:0]   cfg_height,
  input  logic                                  cfg_stride,
  output logic                                  busy,
  output logic                                  cfg_err,
  output logic                                  done,
  input  logic [CH*DATA_WIDTH-1:0]              s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [K*K*CH*DATA_WIDTH-1:0]          m_window,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_last
);

  localparam int PW = CH * DATA_WIDTH;
  localparam int WW = $clog2(MAX_IMG_WIDTH + 1);
  localparam int HW = $clog2(MAX_IMG_HEIGHT + 1);
  localparam int AW = $clog2(MAX_IMG_WIDTH);

  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_K   = WW'(K);
  localparam logic [WW-1:0] W_KM1 = WW'(K - 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_IMG_WIDTH);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_K   = HW'(K);
  localparam logic [HW-1:0] H_KM1 = HW'(K - 1);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_IMG_HEIGHT);
  localparam logic [WW:0]   WX_ONE = (WW+1)'(1);
  localparam logic [WW:0]   WX_TWO = (WW+1)'(2);
  localparam logic [HW:0]   HX_ONE = (HW+1)'(1);
  localparam logic [HW:0]   HX_TWO = (HW+1)'(2);

  lwg_state_t r_state, w_state_nxt;

  logic [WW-1:0] r_width, r_col;
  logic [HW-1:0] r_height, r_row;
  logic          r_stride, r_cph, r_rph;
  logic          r_cfg_err, r_done;

  logic          r_vld_p1, r_emit_p1, r_last_p1;
  logic [PW-1:0] r_pix_p1;
  logic [AW-1:0] r_col_p1;

  logic          r_vld_p2, r_last_p2;
  logic [PW-1:0] r_win_p2 [K][K];

  logic          w_advance, w_accept, w_wr_en;
  logic          w_cfg_legal, w_start_ok, w_start_bad;
  logic          w_at_end, w_col_wrap, w_emit, w_last_emit;
  logic          w_col_last, w_row_last, w_s2;
  logic [WW:0]   w_col_step;
  logic [HW:0]   w_row_step;
  logic [PW-1:0] w_rd   [K-1];
  logic [PW-1:0] w_colv [K];

  assign w_advance = !r_vld_p2 || m_ready;
  assign busy      = (r_state == ST_RUN);
  assign s_ready   = busy && w_advance;
  assign w_accept  = s_valid && s_ready;
  assign w_wr_en   = w_advance && r_vld_p1;
  assign cfg_err   = r_cfg_err;
  assign done      = r_done;
  assign m_valid   = r_vld_p2;
  assign m_last    = r_last_p2;

  assign w_cfg_legal = (cfg_width >= W_K) && (cfg_width <= W_MAX) &&
                       (cfg_height >= H_K) && (cfg_height <= H_MAX);

  assign w_s2       = (r_stride == STRIDE_2);
  assign w_at_end   = (r_row == r_height - H_ONE) && (r_col == r_width - W_ONE);
  assign w_col_wrap = (r_col == r_width - W_ONE);

  // Emission needs K-1 completed rows/cols behind the pixel and zero stride phase;
  // the last emission is the one with no further aligned position in either axis.
  assign w_emit      = (r_row >= H_KM1) && (r_col >= W_KM1) && !r_rph && !r_cph;
  assign w_col_step  = w_s2 ? WX_TWO : WX_ONE;
  assign w_row_step  = w_s2 ? HX_TWO : HX_ONE;
  assign w_col_last  = ({1'b0, r_col} + w_col_step) >= {1'b0, r_width};
  assign w_row_last  = ({1'b0, r_row} + w_row_step) >= {1'b0, r_height};
  assign w_last_emit = w_emit && w_col_last && w_row_last;

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept a legal start while idle, return to idle after the last pixel
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_cfg_legal) begin
            w_state_nxt = ST_RUN;
            w_start_ok  = 1'b1;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_accept && w_at_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Config latch plus row/col position and per-axis stride phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width  <= '0;
      r_height <= '0;
      r_stride <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_cph    <= 1'b0;
      r_rph    <= 1'b0;
    end else if (w_start_ok) begin
      r_width  <= cfg_width;
      r_height <= cfg_height;
      r_stride <= cfg_stride;
      r_col    <= '0;
      r_row    <= '0;
      r_cph    <= 1'b0;
      r_rph    <= 1'b0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_cph <= 1'b0;
        r_row <= r_row + H_ONE;
        r_rph <= (r_row >= H_KM1 && w_s2) ? ~r_rph : 1'b0;
      end else begin
        r_col <= r_col + W_ONE;
        r_cph <= (r_col >= W_KM1 && w_s2) ? ~r_cph : 1'b0;
      end
    end
  end

  // One-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cfg_err <= w_start_bad;
      r_done    <= w_accept && w_at_end;
    end
  end

  // ---- stage 1: RAM read issued, pixel and emission flags captured ----
  // Stage-1 control flags advance only when the pipeline is not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_emit_p1 <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1  <= w_accept;
      r_emit_p1 <= w_accept && w_emit;
      r_last_p1 <= w_accept && w_last_emit;
    end
  end

  // Stage-1 data; held while stalled because nothing is accepted then
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pix_p1 <= s_data;
      r_col_p1 <= r_col[AW-1:0];
    end
  end

  // Row RAMs: index 0 is the oldest row. Each RAM is written back with the
  // value just read from the next-newer one, so rows ripple down one step per line.
  for (genvar i = 0; i < K - 1; i++) begin : g_row
    logic [PW-1:0] w_wr_data;
    if (i == K - 2) begin : g_newest
      assign w_wr_data = r_pix_p1;
    end else begin : g_older
      assign w_wr_data = w_rd[i+1];
    end
    lb_row_ram #(
      .WIDTH (PW),
      .DEPTH (MAX_IMG_WIDTH),
      .AW    (AW)
    ) u_ram (
      .clk       (clk),
      .i_rd_en   (w_accept),
      .i_rd_addr (r_col[AW-1:0]),
      .o_rd_data (w_rd[i]),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_col_p1),
      .i_wr_data (w_wr_data)
    );
    assign w_colv[i] = w_rd[i];
  end
  assign w_colv[K-1] = r_pix_p1;

  // ---- stage 2: window shift register and output handshake ----
  // Shift in one column per pixel; publish the window only at emitting positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          r_win_p2[r][c] <= '0;
    end else if (w_advance) begin
      r_vld_p2  <= r_vld_p1 && r_emit_p1;
      r_last_p2 <= r_vld_p1 && r_emit_p1 && r_last_p1;
      if (r_vld_p1) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++)
            r_win_p2[r][c] <= r_win_p2[r][c+1];
          r_win_p2[r][K-1] <= w_colv[r];
        end
      end
    end
  end

  // Flatten the window: element (r,c) occupies slot r*K+c
  always_comb begin
    m_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        m_window[(r*K+c)*PW +: PW] = r_win_p2[r][c];
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen (K=3, CH=1, DATA_WIDTH=16).
module tb_line_window_gen;

  localparam int DW   = 16;
  localparam int CH   = 1;
  localparam int K    = 3;
  localparam int MW   = 64;
  localparam int MH   = 64;
  localparam int WW   = $clog2(MW + 1);
  localparam int HW   = $clog2(MH + 1);
  localparam int WINW = K * K * CH * DW;

  logic              clk, rst_n, start, cfg_stride;
  logic [WW-1:0]     cfg_width;
  logic [HW-1:0]     cfg_height;
  logic              busy, cfg_err, done;
  logic [CH*DW-1:0]  s_data;
  logic              s_valid, s_ready;
  logic [WINW-1:0]   m_window;
  logic              m_valid, m_ready, m_last;

  line_window_gen #(
    .DATA_WIDTH (DW), .CH (CH), .K (K),
    .MAX_IMG_WIDTH (MW), .MAX_IMG_HEIGHT (MH)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .cfg_width (cfg_width), .cfg_height (cfg_height), .cfg_stride (cfg_stride),
    .busy (busy), .cfg_err (cfg_err), .done (done),
    .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .m_window (m_window), .m_valid (m_valid), .m_ready (m_ready), .m_last (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w; int h; bit s; int base; int exp_cnt; int exp_last_tl;
  } frame_vec_t;

  typedef struct {
    logic [WINW-1:0] win; bit last; int tag;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   total, bad, g_cyc;
  int   cnt_by_tag[16];
  int   last_tl_by_tag[16];
  bit   rand_ready, exp_busy, exp_done;
  frame_vec_t vecs[6];

  task automatic check(input string name, input logic [WINW+1:0] act, input logic [WINW+1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
    return DW'(base + r * 16 + c);
  endfunction

  task automatic push_expected(input int w, input int h, input bit s, input int base, input int tag);
    int step, nr, nc;
    exp_t e;
    step = s ? 2 : 1;
    nr = (h - K) / step + 1;
    nc = (w - K) / step + 1;
    for (int wr = 0; wr < nr; wr++)
      for (int wc = 0; wc < nc; wc++) begin
        e.win = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e.win[(r*K+c)*DW +: DW] = pix(base, wr*step + r, wc*step + c);
        e.last = (wr == nr - 1) && (wc == nc - 1);
        e.tag  = tag;
        exp_q.push_back(e);
      end
  endtask

  // Drive one frame cycle by cycle, scoring every handshake on the way.
  task automatic run_frame(input int w, input int h, input bit s, input int base, input int tag,
                           input bit leave_pending, input int stop_after, input int poke_at);
    int n, idx, cyc, step, r, c;
    bit started, poked, legal_start, fin, acc, macc, hold_pending, hold_last, emit;
    logic [WINW-1:0] hold_win;
    exp_t e;
    n = w * h; idx = 0; cyc = 0; step = s ? 2 : 1;
    started = 0; poked = 0; fin = 0; hold_pending = 0; hold_last = 0; hold_win = '0;
    push_expected(w, h, s, base, tag);
    while (!fin) begin
      @(negedge clk);
      legal_start = 0;
      if (!started) begin
        start = 1; cfg_width = WW'(w); cfg_height = HW'(h); cfg_stride = s;
        started = 1; legal_start = 1;
      end else if (poke_at >= 0 && idx >= poke_at && !poked) begin
        start = 1; cfg_width = WW'(2); cfg_height = HW'(h); cfg_stride = ~s; poked = 1;
      end else begin
        start = 0;
      end
      s_valid = (idx < n);
      s_data  = pix(base, idx / w, idx % w);
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("cfg_err_idle", cfg_err, 0);
      if (hold_pending) check("stall_hold", {m_valid, m_last, m_window}, {1'b1, hold_last, hold_win});
      if (m_valid && !m_ready) check("stall_sready", s_ready, 0);
      acc  = s_valid && s_ready;
      macc = m_valid && m_ready;
      if (macc) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_window: got %0h want none", m_window);
        end else begin
          e = exp_q.pop_front();
          check("window", {m_last, m_window}, {e.last, e.win});
          cnt_by_tag[e.tag]++;
          if (m_last) last_tl_by_tag[e.tag] = int'(m_window[DW-1:0]);
        end
        if (lat_q.size() != 0) begin
          if (!rand_ready) check("latency", g_cyc, lat_q[0]);
          void'(lat_q.pop_front());
        end
      end
      hold_pending = m_valid && !m_ready;
      hold_win = m_window; hold_last = m_last;
      if (acc) begin
        r = idx / w; c = idx % w;
        emit = (r >= K-1) && (c >= K-1) && ((r - (K-1)) % step == 0) && ((c - (K-1)) % step == 0);
        if (emit) lat_q.push_back(g_cyc + 2);
      end
      exp_done = acc && (idx == n - 1);
      if (legal_start && !exp_busy) exp_busy = 1;
      if (acc && idx == n - 1) exp_busy = 0;
      if (acc) idx++;
      cyc++; g_cyc++;
      if (stop_after >= 0 && idx >= stop_after) fin = 1;
      else if (idx == n && !exp_done && (leave_pending || exp_q.size() == 0)) fin = 1;
      if (cyc > 40 * n + 200) begin
        total++; bad++;
        $display("FAIL timeout: got idx=%0d pending=%0d want idx=%0d pending=0", idx, exp_q.size(), n);
        fin = 1;
      end
    end
    start = 0;
    s_valid = 0;
  endtask

  // Rejected start: single cfg_err pulse, no busy, input side stays closed.
  task automatic cfg_bad(input int w, input int h);
    @(negedge clk);
    start = 1; cfg_width = WW'(w); cfg_height = HW'(h); cfg_stride = 0;
    s_valid = 1; m_ready = 1;
    @(negedge clk);
    start = 0;
    #1;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    check("cfg_err_sready", s_ready, 0);
    @(negedge clk);
    #1;
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_err_busy2", busy, 0);
    s_valid = 0;
  endtask

  initial begin
    total = 0; bad = 0; g_cyc = 0;
    rand_ready = 0; exp_busy = 0; exp_done = 0;
    for (int i = 0; i < 16; i++) begin cnt_by_tag[i] = 0; last_tl_by_tag[i] = -1; end

    //          w   h  s  base    cnt last_tl
    vecs[0] = '{8,  6, 0, 'h000, 24, 'h035};
    vecs[1] = '{8,  6, 1, 'h000,  6, 'h024};
    vecs[2] = '{3,  3, 0, 'h100,  1, 'h100};
    vecs[3] = '{5,  4, 1, 'h000,  2, 'h002};
    vecs[4] = '{64, 3, 0, 'h000, 62, 'h03D};
    vecs[5] = '{7,  7, 1, 'h200,  9, 'h244};

    rst_n = 0; start = 0; cfg_width = '0; cfg_height = '0; cfg_stride = 0;
    s_data = '0; s_valid = 0; m_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_done", done, 0);
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mlast", m_last, 0);
    check("rst_window", m_window, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].base, i, 0, -1, -1);
      check("frame_count", cnt_by_tag[i], vecs[i].exp_cnt);
      check("frame_last_tl", last_tl_by_tag[i], vecs[i].exp_last_tl);
    end

    cfg_bad(2, 6);
    cfg_bad(8, 2);
    cfg_bad(65, 6);
    cfg_bad(8, 65);

    rand_ready = 1;
    run_frame(8, 6, 0, 'h000, 6, 0, -1, -1);
    rand_ready = 0;
    check("rand_count", cnt_by_tag[6], 24);
    check("rand_last_tl", last_tl_by_tag[6], 'h035);

    run_frame(8, 6, 0, 'h040, 7, 0, -1, 10);
    check("poke_count", cnt_by_tag[7], 24);
    check("poke_last_tl", last_tl_by_tag[7], 'h075);

    run_frame(8, 6, 0, 'h000, 8, 0, 20, -1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sready", s_ready, 0);
    check("arst_mvalid", m_valid, 0);
    check("arst_mlast", m_last, 0);
    check("arst_window", m_window, 0);
    check("arst_done", done, 0);
    check("arst_cfg_err", cfg_err, 0);
    exp_q.delete(); lat_q.delete();
    exp_busy = 0; exp_done = 0;
    start = 0; s_valid = 0; m_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_frame(8, 6, 0, 'h000, 9, 0, -1, -1);
    check("post_rst_count", cnt_by_tag[9], 24);
    check("post_rst_last_tl", last_tl_by_tag[9], 'h035);

    run_frame(8, 6, 0, 'h000, 10, 1, -1, -1);
    run_frame(8, 6, 0, 'h080, 11, 0, -1, -1);
    check("b2b_first_count", cnt_by_tag[10], 24);
    check("b2b_second_count", cnt_by_tag[11], 24);
    check("b2b_second_last_tl", last_tl_by_tag[11], 'h0B5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
